icache_sa: RTL and testbench

Parametrised set-associative instruction cache with multi-word lines, sitting between the IF stage and the memory controller. A hit is answered combinationally in the lookup cycle. A miss starts a refill FSM that fetches a whole line one word at a time and forwards the requested word as soon as it arrives. It adds per-set LRU replacement, a one-cycle flush (`fence.i`) and abort-safe refill.

---
 rtl/icache_sa_pkg.sv | 23 ++
 rtl/icache_sa_if.sv | 25 ++
 rtl/icache_way.sv | 57 +++++
 rtl/icache_sa.sv | 213 +++++++++++++++++++++
 tb/tb_icache_sa.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/icache_sa_pkg.sv
// icache_sa shared types: FSM encodings, parameter defaults, constants.
// Imported by the way array, the interface users and the top.
package icache_sa_pkg;

  localparam int ADDR_W_D     = 18;
  localparam int SETS_D       = 64;
  localparam int WAYS_D       = 2;
  localparam int LINE_WORDS_D = 4;

  localparam logic Hit     = 1'b1;
  localparam logic Miss    = 1'b0;
  localparam logic Valid   = 1'b1;
  localparam logic Invalid = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0;

  typedef enum logic [1:0] {
    IcIdle   = 2'd0,
    IcRefill = 2'd1,
    IcAbort  = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_sa_if.sv
// IF-side lookup and memory-side refill bus of icache_sa.
// slave: cache side; master: IF stage + memory controller side.
interface icache_sa_if;
  logic        rd_valid_i;
  logic [31:0] rd_addr_i;
  logic        hit_o;
  logic [31:0] inst_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;

  modport slave (
    input  rd_valid_i, rd_addr_i, flush_i,
    input  mem_valid_i, mem_data_i,
    output hit_o, inst_o, mem_req_o, mem_addr_o
  );

  modport master (
    output rd_valid_i, rd_addr_i, flush_i,
    output mem_valid_i, mem_data_i,
    input  hit_o, inst_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache_way.sv
// One cache way: valid/tag/data arrays, word write, bulk invalidate.
// Ports: write (windex/woff/wdata/wtag), read (rindex/roff/rtag) -> vld/match/rdata.
module icache_way
  import icache_sa_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int OFF_W = 2,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inval,
  input  logic             we,
  input  logic             tag_we,
  input  logic [IDX_W-1:0] windex,
  input  logic [OFF_W-1:0] woff,
  input  logic [31:0]      wdata,
  input  logic [TAG_W-1:0] wtag,
  input  logic [IDX_W-1:0] rindex,
  input  logic [OFF_W-1:0] roff,
  input  logic [TAG_W-1:0] rtag,
  output logic             vld,
  output logic             match,
  output logic [31:0]      rdata
);

  localparam int SETS = 1 << IDX_W;

  logic [SETS-1:0]  vld_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS << OFF_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= {SETS{Invalid}};
    end else if (inval) begin
      vld_q <= {SETS{Invalid}};
    end else if (tag_we) begin
      vld_q[windex] <= Valid;
    end
  end

  // Tags and data carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[windex] <= wtag;
    end
    if (we) begin
      data_q[{windex, woff}] <= wdata;
    end
  end

  assign vld   = vld_q[rindex];
  assign match = vld && (tag_q[rindex] == rtag);
  assign rdata = data_q[{rindex, roff}];

endmodule

// File: rtl/icache_sa.sv
// Set-associative I-cache: 0-cycle hit, LRU, line refill FSM with forwarding.
// Ports: clk, rst (async low), rdy (global stall), bus (icache_sa_if.slave).
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_D,
  parameter int SETS       = SETS_D,
  parameter int WAYS       = WAYS_D,
  parameter int LINE_WORDS = LINE_WORDS_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  icache_sa_if.slave  bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int LA_W  = ADDR_W - 2 - OFF_W;
  localparam int TAG_W = LA_W - IDX_W;

  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  ic_state_e        state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [LA_W-1:0]  base_q, base_d;
  logic             victim_q, victim_d;
  logic [SETS-1:0]  lru_q;

  logic [OFF_W-1:0] r_off;
  logic [LA_W-1:0]  r_line;
  logic [IDX_W-1:0] r_idx, b_idx;
  logic [TAG_W-1:0] r_tag, b_tag;

  logic [WAYS-1:0]  vld;
  logic [WAYS-1:0]  match;
  logic [31:0]      rdata [WAYS];

  logic        beat, flush, fill, done;
  logic        any_match, victim, hit_way;
  logic        hit, req;
  logic [31:0] inst, vdata;
  logic        unused;

  assign r_off  = bus.rd_addr_i[2 +: OFF_W];
  assign r_line = bus.rd_addr_i[2+OFF_W +: LA_W];
  assign r_idx  = r_line[IDX_W-1:0];
  assign r_tag  = r_line[LA_W-1 -: TAG_W];
  assign b_idx  = base_q[IDX_W-1:0];
  assign b_tag  = base_q[LA_W-1 -: TAG_W];
  assign unused = ^bus.rd_addr_i;

  // A beat only counts while a refill/abort is outstanding and not stalled.
  assign beat  = rdy && bus.mem_valid_i && (state_q != IcIdle);
  assign flush = rdy && bus.flush_i;
  assign fill  = beat && (state_q == IcRefill) && !bus.flush_i;
  assign done  = fill && (cnt_q == LAST);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .IDX_W (IDX_W),
      .OFF_W (OFF_W),
      .TAG_W (TAG_W)
    ) u_way (
      .clk    (clk),
      .rst    (rst),
      .inval  (flush),
      .we     (fill && (victim_q == 1'(w))),
      .tag_we (done && (victim_q == 1'(w))),
      .windex (b_idx),
      .woff   (cnt_q),
      .wdata  (bus.mem_data_i),
      .wtag   (b_tag),
      .rindex (r_idx),
      .roff   (r_off),
      .rtag   (r_tag),
      .vld    (vld[w]),
      .match  (match[w]),
      .rdata  (rdata[w])
    );
  end

  assign any_match = |match;

  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!vld[0]) begin
        victim = 1'b0;
      end else if (!vld[WAYS-1]) begin
        victim = 1'b1;
      end else begin
        victim = lru_q[r_idx];
      end
    end
  end

  always_comb begin
    vdata = ZeroWord;
    for (int w = 0; w < WAYS; w++) begin
      if (victim_q == 1'(w)) begin
        vdata = rdata[w];
      end
    end
  end

  // Lookup: array hit in IDLE; during REFILL only the line
  // being filled answers, from the array or the beat bus.
  always_comb begin
    hit     = Miss;
    inst    = ZeroWord;
    hit_way = 1'b0;
    if (rdy && bus.rd_valid_i && !bus.flush_i) begin
      unique case (state_q)
        IcIdle: begin
          for (int w = 0; w < WAYS; w++) begin
            if (match[w]) begin
              hit     = Hit;
              inst    = rdata[w];
              hit_way = 1'(w);
            end
          end
        end
        IcRefill: begin
          if (r_line == base_q) begin
            if (bus.mem_valid_i && (r_off == cnt_q)) begin
              hit  = Hit;
              inst = bus.mem_data_i;
            end else if (r_off < cnt_q) begin
              hit  = Hit;
              inst = vdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    victim_d = victim_q;
    unique case (state_q)
      IcIdle: begin
        if (rdy && bus.rd_valid_i && !bus.flush_i && !any_match) begin
          state_d  = IcRefill;
          cnt_d    = '0;
          base_d   = r_line;
          victim_d = victim;
        end
      end
      IcRefill: begin
        if (flush) begin
          state_d = IcAbort;
        end
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IcIdle;
          end
        end
      end
      IcAbort: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IcIdle;
          end
        end
      end
      default: begin
        state_d = IcIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IcIdle;
      cnt_q    <= '0;
      base_q   <= '0;
      victim_q <= 1'b0;
    end else if (rdy) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      victim_q <= victim_d;
    end
  end

  // LRU bit names the way to evict next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lru_q <= '0;
    end else if (WAYS == 2) begin
      if (hit && (state_q == IcIdle)) begin
        lru_q[r_idx] <= ~hit_way;
      end else if (done) begin
        lru_q[b_idx] <= ~victim_q;
      end
    end
  end

  assign req            = (state_q != IcIdle);
  assign bus.hit_o      = hit;
  assign bus.inst_o     = inst;
  assign bus.mem_req_o  = req;
  assign bus.mem_addr_o = req ? 32'({base_q, cnt_q, 2'b00}) : ZeroWord;

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa (defaults: 64 sets, 2 ways, 4-word lines).
// Stimulus pushes expected lookups/beat addresses; a negedge monitor checks them.
module tb_icache_sa;
  import icache_sa_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;

  icache_sa_if bus();

  icache_sa u_dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] hq [$];
  logic [31:0] aq [$];
  logic [32:0] he;
  logic [31:0] ae;

  always @(negedge clk) begin
    if (rst && bus.rd_valid_i) begin
      n_cmp++;
      if (hq.size() == 0) begin
        n_bad++;
        $display("FAIL lookup %h: unexpected, got hit=%0b inst=%h",
                 bus.rd_addr_i, bus.hit_o, bus.inst_o);
      end else begin
        he = hq.pop_front();
        if ({bus.hit_o, bus.inst_o} !== he) begin
          n_bad++;
          $display("FAIL lookup %h: got hit=%0b inst=%h want hit=%0b inst=%h",
                   bus.rd_addr_i, bus.hit_o, bus.inst_o, he[32], he[31:0]);
        end
      end
    end
    if (rst && rdy && bus.mem_valid_i) begin
      n_cmp++;
      if (aq.size() == 0) begin
        n_bad++;
        $display("FAIL beat: unexpected, got req=%0b addr=%h",
                 bus.mem_req_o, bus.mem_addr_o);
      end else begin
        ae = aq.pop_front();
        if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, ae}) begin
          n_bad++;
          $display("FAIL beat: got req=%0b addr=%h want req=1 addr=%h",
                   bus.mem_req_o, bus.mem_addr_o, ae);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [32:0] got,
                     input logic [32:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step(input logic rv, input logic [31:0] a,
                      input logic fl, input logic mv,
                      input logic [31:0] md, input logic eh,
                      input logic [31:0] ei, input logic [31:0] ea);
    bus.rd_valid_i  = rv;
    bus.rd_addr_i   = a;
    bus.flush_i     = fl;
    bus.mem_valid_i = mv;
    bus.mem_data_i  = md;
    if (rv) hq.push_back({eh, ei});
    if (mv && rdy) aq.push_back(ea);
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] a, input logic eh,
                      input logic [31:0] ei);
    step(1'b1, a, 1'b0, 1'b0, ZeroWord, eh, ei, ZeroWord);
  endtask

  task automatic beat(input logic rv, input logic [31:0] a,
                      input logic [31:0] md, input logic [31:0] ea,
                      input logic eh, input logic [31:0] ei);
    step(rv, a, 1'b0, 1'b1, md, eh, ei, ea);
  endtask

  task automatic idle();
    step(1'b0, ZeroWord, 1'b0, 1'b0, ZeroWord, Miss, ZeroWord, ZeroWord);
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] db);
    logic [31:0] b;
    b = a & ~32'hF;
    look(a, Miss, ZeroWord);
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, ZeroWord, db + 32'(i), b + 32'(4 * i), Miss, ZeroWord);
    end
  endtask

  initial begin
    bus.rd_valid_i  = 1'b0;
    bus.rd_addr_i   = '0;
    bus.flush_i     = 1'b0;
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit", 33'(bus.hit_o), 33'd0);
    chk("rst_inst", 33'(bus.inst_o), 33'd0);
    chk("rst_req", 33'(bus.mem_req_o), 33'd0);
    chk("rst_addr", 33'(bus.mem_addr_o), 33'd0);
    rst = 1'b1;
    rdy = 1'b1;
    idle();

    // cold miss with forwarding of word 0
    look(32'h100, Miss, ZeroWord);
    chk("req_rise", 33'(bus.mem_req_o), 33'd1);
    beat(1'b1, 32'h100, 32'hA0, 32'h100, Hit, 32'hA0);
    beat(1'b0, ZeroWord, 32'hA1, 32'h104, Miss, ZeroWord);
    beat(1'b0, ZeroWord, 32'hA2, 32'h108, Miss, ZeroWord);
    beat(1'b0, ZeroWord, 32'hA3, 32'h10C, Miss, ZeroWord);
    look(32'h108, Hit, 32'hA2);
    look(32'h100, Hit, 32'hA0);

    // forwarding of the last word, partial-line array hit
    look(32'h20C, Miss, ZeroWord);
    beat(1'b1, 32'h20C, 32'hB0, 32'h200, Miss, ZeroWord);
    beat(1'b1, 32'h20C, 32'hB1, 32'h204, Miss, ZeroWord);
    look(32'h204, Hit, 32'hB1);
    look(32'h100, Miss, ZeroWord);
    beat(1'b1, 32'h20C, 32'hB2, 32'h208, Miss, ZeroWord);
    beat(1'b1, 32'h20C, 32'hB3, 32'h20C, Hit, 32'hB3);
    look(32'h200, Hit, 32'hB0);

    // LRU eviction in set 0
    fill(32'h000, 32'h1000);
    fill(32'h400, 32'h2000);
    look(32'h000, Hit, 32'h1000);
    fill(32'h800, 32'h3000);
    look(32'h004, Hit, 32'h1001);
    look(32'h808, Hit, 32'h3002);
    fill(32'h40C, 32'h2000);
    look(32'h40C, Hit, 32'h2003);

    // flush mid-refill
    look(32'h300, Miss, ZeroWord);
    beat(1'b1, 32'h300, 32'h40, 32'h300, Hit, 32'h40);
    beat(1'b0, ZeroWord, 32'h41, 32'h304, Miss, ZeroWord);
    step(1'b1, 32'h300, 1'b1, 1'b0, ZeroWord, Miss, ZeroWord, ZeroWord);
    beat(1'b1, 32'h308, 32'h42, 32'h308, Miss, ZeroWord);
    beat(1'b1, 32'h300, 32'h43, 32'h30C, Miss, ZeroWord);
    chk("abort_done", 33'(bus.mem_req_o), 33'd0);
    fill(32'h300, 32'h50);
    look(32'h304, Hit, 32'h51);
    fill(32'h108, 32'h60);
    look(32'h108, Hit, 32'h62);
    step(1'b1, 32'h500, 1'b1, 1'b0, ZeroWord, Miss, ZeroWord, ZeroWord);
    chk("flush_wins", 33'(bus.mem_req_o), 33'd0);

    // rdy stall during refill
    look(32'h600, Miss, ZeroWord);
    beat(1'b0, ZeroWord, 32'h70, 32'h600, Miss, ZeroWord);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h604, 1'b0, 1'b1, 32'hDEAD, Miss, ZeroWord, ZeroWord);
      chk("stall_hold", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h604});
    end
    rdy = 1'b1;
    beat(1'b1, 32'h604, 32'h71, 32'h604, Hit, 32'h71);
    beat(1'b0, ZeroWord, 32'h72, 32'h608, Miss, ZeroWord);
    beat(1'b0, ZeroWord, 32'h73, 32'h60C, Miss, ZeroWord);
    look(32'h60C, Hit, 32'h73);
    look(32'h600, Hit, 32'h70);
    rdy = 1'b0;
    look(32'h600, Miss, ZeroWord);
    look(32'h900, Miss, ZeroWord);
    rdy = 1'b1;
    chk("stall_idle", 33'(bus.mem_req_o), 33'd0);

    // async reset mid-refill
    look(32'h700, Miss, ZeroWord);
    beat(1'b0, ZeroWord, 32'h80, 32'h700, Miss, ZeroWord);
    bus.mem_valid_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 33'(bus.mem_req_o), 33'd0);
    chk("arst_addr", 33'(bus.mem_addr_o), 33'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    fill(32'h600, 32'h90);
    look(32'h604, Hit, 32'h91);
    fill(32'h100, 32'hC0);
    look(32'h10C, Hit, 32'hC3);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
